alu_share_arbiter: RTL and testbench

//   Shares one external ALU instance between two requesters (req0 = execute stage, req1 = auxiliary/debug engine).

---
 rtl/alu_share_arbiter.sv | 111 +++++++++++
 tb/tb_alu_share_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters.
// One operation in flight: accept in IDLE, drive the ALU in EXEC, hold the result in RESP.
module alu_share_arbiter #(
  parameter int unsigned WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [3:0]            req0_opcode,
  input  logic [WORD_WIDTH-1:0] req0_a,
  input  logic [WORD_WIDTH-1:0] req0_b,
  input  logic [4:0]            req0_sa,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [3:0]            req1_opcode,
  input  logic [WORD_WIDTH-1:0] req1_a,
  input  logic [WORD_WIDTH-1:0] req1_b,
  input  logic [4:0]            req1_sa,
  output logic                  resp0_valid,
  input  logic                  resp0_ready,
  output logic                  resp1_valid,
  input  logic                  resp1_ready,
  output logic [WORD_WIDTH-1:0] resp_result,
  output logic                  resp_zero,
  output logic [3:0]            alu_opcode,
  output logic [WORD_WIDTH-1:0] alu_a,
  output logic [WORD_WIDTH-1:0] alu_b,
  output logic [4:0]            alu_sa,
  input  logic [WORD_WIDTH-1:0] alu_resultado,
  input  logic                  alu_zero
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StExec = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  logic [1:0]            r_state;
  logic                  r_rr_last;  // 1: req1 was granted last, so req0 wins the next tie
  logic                  r_grant;
  logic [3:0]            r_opcode;
  logic [WORD_WIDTH-1:0] r_a;
  logic [WORD_WIDTH-1:0] r_b;
  logic [4:0]            r_sa;
  logic [WORD_WIDTH-1:0] r_result;
  logic                  r_zero;

  logic w_in_idle;
  logic w_ready0;
  logic w_ready1;
  logic w_resp_fire;

  // Reset masks ready so nothing is accepted in the reset cycle.
  always_comb begin
    w_in_idle   = (r_state == StIdle) && !reset;
    w_ready0    = w_in_idle && req0_valid && (!req1_valid || r_rr_last);
    w_ready1    = w_in_idle && req1_valid && (!req0_valid || !r_rr_last);
    w_resp_fire = (r_state == StResp) && (r_grant ? resp1_ready : resp0_ready);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= StIdle;
      r_rr_last <= 1'b1;
      r_grant   <= 1'b0;
      r_opcode  <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_sa      <= '0;
      r_result  <= '0;
      r_zero    <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_ready0 || w_ready1) begin
            r_opcode  <= w_ready1 ? req1_opcode : req0_opcode;
            r_a       <= w_ready1 ? req1_a : req0_a;
            r_b       <= w_ready1 ? req1_b : req0_b;
            r_sa      <= w_ready1 ? req1_sa : req0_sa;
            r_grant   <= w_ready1;
            r_rr_last <= w_ready1;
            r_state   <= StExec;
          end
        end
        StExec: begin
          r_result <= alu_resultado;
          r_zero   <= alu_zero;
          r_state  <= StResp;
        end
        StResp: begin
          if (w_resp_fire) begin
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign req0_ready  = w_ready0;
  assign req1_ready  = w_ready1;
  assign resp0_valid = (r_state == StResp) && !r_grant;
  assign resp1_valid = (r_state == StResp) && r_grant;
  assign resp_result = r_result;
  assign resp_zero   = r_zero;
  assign alu_opcode  = r_opcode;
  assign alu_a       = r_a;
  assign alu_b       = r_b;
  assign alu_sa      = r_sa;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: behavioural ALU, scoreboard fed at request handshake,
// table-driven operations plus hand-written tie, fairness, backpressure, reset and shift sequences.
module tb_alu_share_arbiter;

  localparam logic [3:0] OpAnd = 4'b0000;
  localparam logic [3:0] OpOr  = 4'b0001;
  localparam logic [3:0] OpAdd = 4'b0010;
  localparam logic [3:0] OpXor = 4'b0011;
  localparam logic [3:0] OpSll = 4'b0100;
  localparam logic [3:0] OpSub = 4'b0110;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]  req0_opcode, req1_opcode;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [4:0]  req0_sa, req1_sa;
  logic        resp0_valid, resp0_ready, resp1_valid, resp1_ready;
  logic [31:0] resp_result;
  logic        resp_zero;
  logic [3:0]  alu_opcode;
  logic [31:0] alu_a, alu_b, alu_resultado;
  logic [4:0]  alu_sa;
  logic        alu_zero;

  alu_share_arbiter #(.WORD_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
    .req0_a(req0_a), .req0_b(req0_b), .req0_sa(req0_sa),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
    .req1_a(req1_a), .req1_b(req1_b), .req1_sa(req1_sa),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .resp_result(resp_result), .resp_zero(resp_zero),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_sa(alu_sa),
    .alu_resultado(alu_resultado), .alu_zero(alu_zero)
  );

  always #5 clk = ~clk;

  // Behavioural ALU attached to the arbiter's ALU port.
  always_comb begin
    alu_resultado = '0;
    case (alu_opcode)
      OpAnd:   alu_resultado = alu_a & alu_b;
      OpOr:    alu_resultado = alu_a | alu_b;
      OpAdd:   alu_resultado = alu_a + alu_b;
      OpXor:   alu_resultado = alu_a ^ alu_b;
      OpSll:   alu_resultado = alu_b << alu_sa;
      OpSub:   alu_resultado = alu_a - alu_b;
      default: alu_resultado = '0;
    endcase
    alu_zero = (alu_resultado == 32'd0);
  end

  typedef struct {
    int          id;
    logic [31:0] res;
    logic        zero;
    int          cyc;
  } sb_t;

  typedef struct {
    int          id;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sa;
    logic [31:0] res;
    logic        zero;
  } vec_t;

  sb_t         q[$];
  int          grants[$];
  logic [31:0] exp_res [2];
  logic        exp_zero [2];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: event did not occur as required (t=%0t)", name, $time);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: scoreboard push on request handshake, pop/compare on response handshake.
  initial begin
    bit prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_valid = 1'b0;
      end else begin
        if (req0_valid && req1_valid) check("ready_onehot", {31'd0, req0_ready & req1_ready}, 0);
        if (req0_valid && req0_ready) begin
          q.push_back('{id: 0, res: exp_res[0], zero: exp_zero[0], cyc: cyc});
          grants.push_back(0);
        end
        if (req1_valid && req1_ready) begin
          q.push_back('{id: 1, res: exp_res[1], zero: exp_zero[1], cyc: cyc});
          grants.push_back(1);
        end
        if (resp0_valid || resp1_valid) begin
          check("resp_overlap", {31'd0, resp0_valid & resp1_valid}, 0);
          if (q.size() == 0) begin
            fail("stale_resp");
          end else begin
            if (!prev_valid) begin
              check("resp_latency", cyc - q[0].cyc, 2);
              check("resp_id", {31'd0, resp1_valid}, q[0].id);
            end
            if ((resp0_valid && resp0_ready) || (resp1_valid && resp1_ready)) begin
              sb_t e;
              e = q.pop_front();
              check("resp_result", resp_result, e.res);
              check("resp_zero", {31'd0, resp_zero}, {31'd0, e.zero});
            end
          end
        end
        prev_valid = resp0_valid | resp1_valid;
      end
    end
  end

  task automatic set_req(input int id, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] sa,
                         input logic [31:0] er, input logic ez);
    exp_res[id]  = er;
    exp_zero[id] = ez;
    if (id == 0) begin
      req0_opcode = op; req0_a = a; req0_b = b; req0_sa = sa; req0_valid = 1'b1;
    end else begin
      req1_opcode = op; req1_a = a; req1_b = b; req1_sa = sa; req1_valid = 1'b1;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the handshake edge.
  task automatic wait_accept(input int id, output int waited);
    bit got = 1'b0;
    waited = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if ((id == 0) ? req0_ready : req1_ready) begin
        waited = i;
        got = 1'b1;
        break;
      end
    end
    if (!got) fail("accept_timeout");
    @(posedge clk);
    #1;
    if (id == 0) req0_valid = 1'b0;
    else req1_valid = 1'b0;
  endtask

  task automatic issue(input int id, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] sa,
                       input logic [31:0] er, input logic ez);
    int w;
    set_req(id, op, a, b, sa, er, ez);
    wait_accept(id, w);
  endtask

  task automatic drain();
    bit done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (q.size() == 0 && !resp0_valid && !resp1_valid) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) fail("drain_timeout");
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    int   w;
    vecs[0] = '{0, OpAdd, 32'd5,         32'd7,         5'd0, 32'd12,        1'b0};
    vecs[1] = '{1, OpAdd, 32'hFFFF_FFFF, 32'd1,         5'd0, 32'd0,         1'b1};
    vecs[2] = '{0, OpSub, 32'd9,         32'd9,         5'd0, 32'd0,         1'b1};
    vecs[3] = '{1, OpSub, 32'd3,         32'd5,         5'd0, 32'hFFFF_FFFE, 1'b0};
    vecs[4] = '{0, OpOr,  32'd3,         32'd4,         5'd0, 32'd7,         1'b0};
    vecs[5] = '{1, OpAnd, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd0, 32'h00F0_00F0, 1'b0};
    vecs[6] = '{0, OpXor, 32'hAAAA_5555, 32'hFFFF_0000, 5'd0, 32'h5555_5555, 1'b0};
    vecs[7] = '{1, OpSll, 32'd0,         32'd3,         5'd4, 32'd48,        1'b0};

    reset = 1'b1;
    req1_valid = 1'b0; req1_opcode = '0; req1_a = '0; req1_b = '0; req1_sa = '0;
    resp0_ready = 1'b1; resp1_ready = 1'b1;
    set_req(0, OpAdd, 32'd1, 32'd1, 5'd0, 32'd2, 1'b0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("rst_req0_ready", {31'd0, req0_ready}, 0);
    check("rst_resp_valid", {30'd0, resp0_valid, resp1_valid}, 0);
    check("rst_alu_opcode", {28'd0, alu_opcode}, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_resp_result", resp_result, 0);
    check("rst_resp_zero", {31'd0, resp_zero}, 0);
    req0_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Single op accepted in the same cycle, response two cycles later.
    set_req(0, OpAdd, 32'd5, 32'd7, 5'd0, 32'd12, 1'b0);
    wait_accept(0, w);
    check("t1_ready_same_cycle", w, 0);
    drain();

    for (int i = 0; i < 8; i++) begin
      issue(vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sa, vecs[i].res, vecs[i].zero);
      drain();
    end

    // Tie from reset: req0 first, then req1.
    reset_pulse();
    grants.delete();
    set_req(0, OpSub, 32'd9, 32'd9, 5'd0, 32'd0, 1'b1);
    set_req(1, OpOr, 32'd3, 32'd4, 5'd0, 32'd7, 1'b0);
    fork
      begin int w0; wait_accept(0, w0); end
      begin int w1; wait_accept(1, w1); end
    join
    drain();
    check("tie_count", grants.size(), 2);
    if (grants.size() == 2) begin
      check("tie_first", grants[0], 0);
      check("tie_second", grants[1], 1);
    end

    // Fairness with both requesters continuously valid.
    grants.delete();
    fork
      for (int i = 0; i < 4; i++) issue(0, OpAdd, i, 32'd1, 5'd0, i + 1, 1'b0);
      for (int j = 0; j < 4; j++) issue(1, OpXor, j, 32'd3, 5'd0, j ^ 3, ((j ^ 3) == 0));
    join
    drain();
    check("fair_count", grants.size(), 8);
    for (int k = 1; k < grants.size(); k++) check("fair_alternate", {31'd0, grants[k] != grants[k-1]}, 1);

    // Backpressure on resp1 with req0 waiting.
    resp1_ready = 1'b0;
    issue(1, OpOr, 32'd3, 32'd4, 5'd0, 32'd7, 1'b0);
    set_req(0, OpAdd, 32'd1, 32'd1, 5'd0, 32'd2, 1'b0);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_resp1_valid", {31'd0, resp1_valid}, 1);
      check("bp_result_held", resp_result, 32'd7);
      check("bp_ready_low", {30'd0, req0_ready, req1_ready}, 0);
    end
    @(posedge clk);
    #1;
    resp1_ready = 1'b1;
    wait_accept(0, w);
    drain();

    // Reset while the op is in EXEC: no response afterwards.
    issue(0, OpAdd, 32'd1, 32'd2, 5'd0, 32'd3, 1'b0);
    reset_pulse();
    @(negedge clk);
    check("rst_mid_resp_valid", {30'd0, resp0_valid, resp1_valid}, 0);
    check("rst_mid_result", resp_result, 0);
    check("rst_mid_zero", {31'd0, resp_zero}, 0);
    for (int i = 0; i < 5; i++) @(negedge clk);
    check("rst_mid_no_stale", {30'd0, resp0_valid, resp1_valid}, 0);
    @(posedge clk);
    #1;

    // Shift amount reaches the ALU unchanged.
    issue(1, OpSll, 32'd0, 32'd1, 5'd31, 32'h8000_0000, 1'b0);
    @(negedge clk);
    check("shift_alu_sa", {27'd0, alu_sa}, 31);
    check("shift_alu_opcode", {28'd0, alu_opcode}, {28'd0, OpSll});
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
